// File: rtl/gg_code_loader.sv
// gg_code_loader: turns ASCII Game Genie codes from the ioctl download stream into 38-bit geniecodes words.
// Optional feature macro GG_LOADER_LOWERCASE_EN: lowercase a..z decode the same as uppercase.
`default_nettype none

module gg_code_loader #(
    parameter int MAX_CODES = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        extra_codes,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic [37:0] code,
    output logic [3:0]  code_count,
    output logic        busy,
    output logic        err_format,
    output logic        err_overflow
);

    typedef enum logic [1:0] {IDLE, CLEAR, COLLECT, EMIT} state_t;

    localparam logic [3:0] LAST_SLOT = 4'(MAX_CODES - 1);
    localparam logic [3:0] FULL_CAP  = 4'(MAX_CODES);

    state_t      state, state_d;
    logic        download_q;
    logic        rise;
    logic [3:0]  clr_idx;
    logic [3:0]  letter_cnt;
    logic [3:0]  capacity;
    logic        code_bad;
    logic        hold_valid;
    logic [7:0]  hold_byte;
    logic [3:0]  nib [8];
    logic [37:0] code_d;

    logic [7:0]  in_byte;
    logic [4:0]  in_letter;
    logic        long_code;
    logic [14:0] dec_addr;
    logic [7:0]  dec_cmp;
    logic [7:0]  dec_rep;

    logic letter_take, set_bad, fmt_drop, emit_fire, ovf_set, hold_load, hold_take;

    // {valid, value}: position of the letter in the Genie alphabet APZLGITYEOXUKSVN.
    function automatic logic [4:0] letter_lookup(input logic [7:0] b);
        logic [7:0] u;
        u = b;
`ifdef GG_LOADER_LOWERCASE_EN
        if (b >= "a" && b <= "z") u = b - 8'h20;
`endif
        case (u)
            "A": return 5'h10;
            "P": return 5'h11;
            "Z": return 5'h12;
            "L": return 5'h13;
            "G": return 5'h14;
            "I": return 5'h15;
            "T": return 5'h16;
            "Y": return 5'h17;
            "E": return 5'h18;
            "O": return 5'h19;
            "X": return 5'h1A;
            "U": return 5'h1B;
            "K": return 5'h1C;
            "S": return 5'h1D;
            "V": return 5'h1E;
            "N": return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    function automatic logic is_separator(input logic [7:0] b);
        return b inside {8'h00, 8'h0A, 8'h0D, 8'h20, 8'h2C};
    endfunction

    assign rise      = ioctl_download && !download_q;
    assign busy      = (state != IDLE);
    assign in_byte   = hold_valid ? hold_byte : ioctl_dout;
    assign in_letter = letter_lookup(in_byte);
    assign long_code = (letter_cnt == 4'd8);

    // Genie bit scramble; the final letter supplies replace bit 3.
    assign dec_addr = {nib[3][2:0], nib[4][3], nib[5][2:0], nib[1][3],
                       nib[2][2:0], nib[3][3], nib[4][2:0]};
    assign dec_rep  = {nib[0][3], nib[1][2:0], (long_code ? nib[7][3] : nib[5][3]), nib[0][2:0]};
    assign dec_cmp  = {nib[6][3], nib[7][2:0], nib[5][3], nib[6][2:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state;
        code_d      = '0;
        letter_take = 1'b0;
        set_bad     = 1'b0;
        fmt_drop    = 1'b0;
        emit_fire   = 1'b0;
        ovf_set     = 1'b0;
        hold_load   = 1'b0;
        hold_take   = 1'b0;
        if (rise) begin
            state_d = CLEAR;
            code_d  = {1'b1, 4'd0, 33'd0};
        end else begin
            case (state)
                IDLE: ;
                CLEAR: begin
                    code_d = {1'b1, clr_idx, 33'd0};
                    if (clr_idx == LAST_SLOT) state_d = COLLECT;
                    if (ioctl_wr) begin
                        if (hold_valid) ovf_set   = 1'b1;
                        else            hold_load = 1'b1;
                    end
                end
                COLLECT: begin
                    if (hold_valid || ioctl_wr) begin
                        hold_take = hold_valid;
                        hold_load = hold_valid && ioctl_wr;
                        if (in_letter[4]) begin
                            if (letter_cnt == 4'd8) set_bad     = 1'b1;
                            else                    letter_take = 1'b1;
                        end else if (is_separator(in_byte)) begin
                            if (code_bad)                                      fmt_drop = 1'b1;
                            else if (letter_cnt == 4'd6 || letter_cnt == 4'd8) state_d  = EMIT;
                            else if (letter_cnt != 4'd0)                       fmt_drop = 1'b1;
                        end else begin
                            set_bad = 1'b1;
                        end
                    end else if (!ioctl_download) begin
                        // End of download: flush a complete pending code, otherwise finish.
                        if (!code_bad && (letter_cnt == 4'd6 || letter_cnt == 4'd8)) begin
                            state_d = EMIT;
                        end else begin
                            fmt_drop = code_bad || (letter_cnt != 4'd0);
                            state_d  = IDLE;
                        end
                    end
                end
                EMIT: begin
                    if (code_count == capacity) begin
                        ovf_set = 1'b1;
                    end else begin
                        emit_fire = 1'b1;
                        code_d    = {1'b1, code_count, 1'b1, long_code, dec_addr,
                                     (long_code ? dec_cmp : 8'h00), dec_rep};
                    end
                    state_d = ioctl_download ? COLLECT : IDLE;
                end
            endcase
        end
    end

    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            download_q   <= 1'b0;
            code         <= '0;
            code_count   <= '0;
            clr_idx      <= '0;
            letter_cnt   <= '0;
            code_bad     <= 1'b0;
            capacity     <= 4'd3;
            err_format   <= 1'b0;
            err_overflow <= 1'b0;
            hold_valid   <= 1'b0;
            hold_byte    <= '0;
        end else begin
            download_q <= ioctl_download;
            code       <= code_d;
            if (rise) begin
                code_count   <= '0;
                clr_idx      <= 4'd1;
                letter_cnt   <= '0;
                code_bad     <= 1'b0;
                err_format   <= 1'b0;
                err_overflow <= 1'b0;
                capacity     <= extra_codes ? FULL_CAP : 4'd3;
                hold_valid   <= ioctl_wr;
                hold_byte    <= ioctl_dout;
            end else begin
                if (state == CLEAR) clr_idx <= clr_idx + 4'd1;
                if (hold_load) begin
                    hold_valid <= 1'b1;
                    hold_byte  <= ioctl_dout;
                end else if (hold_take) begin
                    hold_valid <= 1'b0;
                end
                if (ovf_set)     err_overflow <= 1'b1;
                if (letter_take) letter_cnt   <= letter_cnt + 4'd1;
                if (set_bad)     code_bad     <= 1'b1;
                if (fmt_drop || state == EMIT) begin
                    letter_cnt <= '0;
                    code_bad   <= 1'b0;
                end
                if (fmt_drop)  err_format <= 1'b1;
                if (emit_fire) code_count <= code_count + 4'd1;
            end
        end
    end

    // NOTE: the letter registers are plain storage qualified by letter_cnt, so they carry no reset.
    always_ff @(posedge clk) begin
        if (letter_take) nib[letter_cnt[2:0]] <= in_letter[3:0];
    end

endmodule

`default_nettype wire
